// File: rtl/fpga_dsp_bus_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared FPGA-to-DSP address/data bus.
// One requester owns the bus per transaction; beats are paced by the DSP's BusReady.
module fpga_dsp_bus_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      Req,
    input  logic [NREQ*AW-1:0]   ReqAddr,
    input  logic [NREQ*DW-1:0]   ReqData,
    input  logic [NREQ*2-1:0]    ReqLen,
    output logic [NREQ-1:0]      Gnt,
    output logic [NREQ-1:0]      BeatAck,
    output logic [AW-1:0]        AddrBus,
    output logic [DW-1:0]        DataBus,
    output logic                 BusValid,
    input  logic                 BusReady,
    output logic                 BusLast,
    output logic                 Busy,
    output logic [1:0]           StateDbg
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [1:0]      beat_cnt;

    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];
    logic [1:0]      len_arr  [NREQ];

    logic [IW-1:0]   pick;
    logic            pick_found;
    logic [IW:0]     sum;
    logic [IW-1:0]   cand;

    genvar g;
    for (g = 0; g < NREQ; g++) begin : g_slice
        assign addr_arr[g] = ReqAddr[g*AW +: AW];
        assign data_arr[g] = ReqData[g*DW +: DW];
        assign len_arr[g]  = ReqLen[g*2 +: 2];
    end

    // Search upward from ptr with wrap; the requester just served sits at the far end.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!pick_found && Req[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    // Handshake: a beat transfers on any rising edge where BusValid and BusReady are
    // both high; while BusReady is low every bus output holds, with no wait limit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            winner   <= '0;
            beat_cnt <= '0;
            AddrBus  <= '0;
            Gnt      <= '0;
            BusValid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        winner   <= pick;
                        AddrBus  <= addr_arr[pick];
                        beat_cnt <= len_arr[pick];
                        Gnt      <= NREQ'(1) << pick;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    BusValid <= 1'b1;
                    state    <= S_XFER;
                end
                S_XFER: begin
                    if (BusValid && BusReady) begin
                        AddrBus  <= AddrBus + 1'b1;
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == 2'd0) begin
                            BusValid <= 1'b0;
                            Gnt      <= '0;
                            state    <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (winner == IW'(NREQ-1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= winner + 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Data follows the owner's live ReqData so the requester can advance after each ack.
    always_comb begin
        DataBus = '0;
        BusLast = 1'b0;
        BeatAck = '0;
        if (state == S_XFER) begin
            DataBus = data_arr[winner];
            BusLast = (beat_cnt == 2'd0);
            if (BusReady) begin
                BeatAck = Gnt;
            end
        end
    end

    assign Busy     = (state != S_IDLE);
    assign StateDbg = state;

endmodule

// File: tb/tb_fpga_dsp_bus_arbiter.sv
// Directed bench for fpga_dsp_bus_arbiter: latency, round-robin order, stalls,
// address wrap, dropped requests and mid-burst reset.
module tb_fpga_dsp_bus_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_XFER    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic                 Clk;
    logic                 Reset;
    logic [NREQ-1:0]      Req;
    logic [NREQ*AW-1:0]   ReqAddr;
    logic [NREQ*DW-1:0]   ReqData;
    logic [NREQ*2-1:0]    ReqLen;
    logic [NREQ-1:0]      Gnt;
    logic [NREQ-1:0]      BeatAck;
    logic [AW-1:0]        AddrBus;
    logic [DW-1:0]        DataBus;
    logic                 BusValid;
    logic                 BusReady;
    logic                 BusLast;
    logic                 Busy;
    logic [1:0]           StateDbg;

    int passed = 0;
    int total  = 0;
    int ack_count = 0;
    int ack_base  = 0;

    fpga_dsp_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .ReqAddr  (ReqAddr),
        .ReqData  (ReqData),
        .ReqLen   (ReqLen),
        .Gnt      (Gnt),
        .BeatAck  (BeatAck),
        .AddrBus  (AddrBus),
        .DataBus  (DataBus),
        .BusValid (BusValid),
        .BusReady (BusReady),
        .BusLast  (BusLast),
        .Busy     (Busy),
        .StateDbg (StateDbg)
    );

    // Clock and watchdog
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    always @(posedge Clk) begin
        if (BeatAck != '0) ack_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic set_req(input int i, input logic [7:0] addr, input logic [1:0] len,
                           input logic [7:0] data);
        ReqAddr[i*AW +: AW] = addr;
        ReqLen[i*2 +: 2]    = len;
        ReqData[i*DW +: DW] = data;
    endtask

    task automatic check_quiet(input string p);
        check({p, "_gnt"},   Gnt,      32'h0);
        check({p, "_ack"},   BeatAck,  32'h0);
        check({p, "_addr"},  AddrBus,  32'h0);
        check({p, "_data"},  DataBus,  32'h0);
        check({p, "_valid"}, BusValid, 32'h0);
        check({p, "_last"},  BusLast,  32'h0);
        check({p, "_busy"},  Busy,     32'h0);
        check({p, "_state"}, StateDbg, ST_IDLE);
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        Reset = 1'b1; Req = '0; ReqAddr = '0; ReqData = '0; ReqLen = '0; BusReady = 1'b0;
        tick(2);
        check_quiet("rst");
        Reset = 1'b0;

        // Three-beat burst from requester 0, BusReady high
        set_req(0, 8'h10, 2'd2, 8'hA0);
        Req = 4'b0001; BusReady = 1'b1;
        tick;
        check("t1_c1_gnt", Gnt, 4'b0001);
        check("t1_c1_state", StateDbg, ST_GRANT);
        check("t1_c1_valid", BusValid, 1'b0);
        Req = '0;
        tick;
        check("t1_c2_valid", BusValid, 1'b1);
        check("t1_c2_addr", AddrBus, 8'h10);
        check("t1_c2_data", DataBus, 8'hA0);
        check("t1_c2_last", BusLast, 1'b0);
        check("t1_c2_ack", BeatAck, 4'b0001);
        set_req(0, 8'h10, 2'd2, 8'hA1);
        tick;
        check("t1_c3_addr", AddrBus, 8'h11);
        check("t1_c3_data", DataBus, 8'hA1);
        check("t1_c3_last", BusLast, 1'b0);
        set_req(0, 8'h10, 2'd2, 8'hA2);
        tick;
        check("t1_c4_addr", AddrBus, 8'h12);
        check("t1_c4_data", DataBus, 8'hA2);
        check("t1_c4_last", BusLast, 1'b1);
        tick;
        check("t1_c5_state", StateDbg, ST_RELEASE);
        check("t1_c5_gnt", Gnt, 4'b0000);
        check("t1_c5_valid", BusValid, 1'b0);
        check("t1_c5_busy", Busy, 1'b1);
        check("t1_c5_data", DataBus, 8'h00);
        tick;
        check("t1_c6_busy", Busy, 1'b0);

        // Round robin with all four requesting single beats
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h30 + 8'(i), 2'd0, 8'hC0 + 8'(i));
        Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            check($sformatf("rr%0d_gnt", k), Gnt, rr_exp[k]);
            if (k == 4) Req = '0;
            tick;
            check($sformatf("rr%0d_last", k), BusLast, 1'b1);
            check($sformatf("rr%0d_ack", k), BeatAck, rr_exp[k]);
            tick(2);
        end
        check("rr_end_busy", Busy, 1'b0);

        // Single beat with BusReady held low for three cycles
        set_req(1, 8'h55, 2'd0, 8'h3C);
        Req = 4'b0010; BusReady = 1'b0;
        tick;
        check("st_c1_gnt", Gnt, 4'b0010);
        Req = '0;
        ack_base = ack_count;
        tick;
        check("st_c2_valid", BusValid, 1'b1);
        check("st_c2_addr", AddrBus, 8'h55);
        check("st_c2_data", DataBus, 8'h3C);
        check("st_c2_ack", BeatAck, 4'b0000);
        tick(2);
        check("st_c4_valid", BusValid, 1'b1);
        check("st_c4_addr", AddrBus, 8'h55);
        check("st_c4_data", DataBus, 8'h3C);
        check("st_c4_ack", BeatAck, 4'b0000);
        check("st_c4_ackcnt", ack_count, ack_base);
        tick;
        BusReady = 1'b1;
        #1;
        check("st_c5_ack", BeatAck, 4'b0010);
        check("st_c5_addr", AddrBus, 8'h55);
        tick;
        check("st_c6_ackcnt", ack_count, ack_base + 1);
        check("st_c6_state", StateDbg, ST_RELEASE);
        check("st_c6_ack", BeatAck, 4'b0000);
        tick;

        // Address wrap across 8'hFF
        set_req(2, 8'hFE, 2'd3, 8'h11);
        Req = 4'b0100;
        tick;
        check("wr_c1_gnt", Gnt, 4'b0100);
        Req = '0;
        tick;
        check("wr_c2_addr", AddrBus, 8'hFE);
        tick;
        check("wr_c3_addr", AddrBus, 8'hFF);
        tick;
        check("wr_c4_addr", AddrBus, 8'h00);
        check("wr_c4_last", BusLast, 1'b0);
        tick;
        check("wr_c5_addr", AddrBus, 8'h01);
        check("wr_c5_last", BusLast, 1'b1);
        tick(2);

        // Winner drops Req in its first XFER cycle; burst still completes
        set_req(3, 8'h20, 2'd3, 8'h5A);
        Req = 4'b1000;
        tick;
        check("dr_c1_gnt", Gnt, 4'b1000);
        tick;
        Req = '0;
        ack_base = ack_count;
        check("dr_c2_ack", BeatAck, 4'b1000);
        check("dr_c2_addr", AddrBus, 8'h20);
        tick(3);
        check("dr_c5_addr", AddrBus, 8'h23);
        check("dr_c5_last", BusLast, 1'b1);
        check("dr_c5_ack", BeatAck, 4'b1000);
        tick;
        check("dr_c6_ackcnt", ack_count, ack_base + 4);
        check("dr_c6_state", StateDbg, ST_RELEASE);
        tick;

        // Reset on the second beat of a four-beat burst
        set_req(1, 8'h40, 2'd3, 8'h66);
        Req = 4'b0010;
        tick;
        check("ab_c1_gnt", Gnt, 4'b0010);
        Req = '0;
        tick(2);
        check("ab_c3_addr", AddrBus, 8'h41);
        Reset = 1'b1;
        tick;
        check_quiet("ab");
        ack_base = ack_count;
        Reset = 1'b0;
        set_req(2, 8'h77, 2'd0, 8'h99);
        Req = 4'b0100;
        tick;
        check("ab_c5_gnt", Gnt, 4'b0100);
        check("ab_c5_state", StateDbg, ST_GRANT);
        check("ab_c5_ackcnt", ack_count, ack_base);
        Req = '0;
        tick;
        check("ab_c6_addr", AddrBus, 8'h77);
        check("ab_c6_data", DataBus, 8'h99);
        check("ab_c6_ack", BeatAck, 4'b0100);
        tick(2);
        check("ab_c8_busy", Busy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fpga_dsp_bus_arbiter.md
# fpga_dsp_bus_arbiter

Round-robin arbiter and transfer sequencer for the shared 8-bit FPGA-to-DSP address/data bus. Up to NREQ on-chip requesters post burst write requests. The block grants one requester at a time and drives AddrBus/DataBus beat-by-beat toward the DSP side under a valid/ready handshake. It sits between the FPGA-side request logic and the Master side of the FPGA-to-DSP interface.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 8, address bus width
- DW, 8, data bus width

Clock and reset: one clock, `Clk`. `Reset` is synchronous and active-high.

- Clk  input  1  system clock; all state updates on its rising edge
- Reset  input  1  synchronous, active-high reset
- Req  input  NREQ  per-requester request level
- ReqAddr  input  NREQ*AW  start address; slice i belongs to requester i
- ReqData  input  NREQ*DW  current beat data; slice i belongs to requester i
- ReqLen  input  NREQ*2  burst length minus one (0..3 means 1..4 beats)
- Gnt  output  NREQ  one-hot grant, held for the whole transaction
- BeatAck  output  NREQ  one-hot pulse when a beat of requester i is accepted
- AddrBus  output  AW  registered beat address
- DataBus  output  DW  beat data
- BusValid  output  1  beat valid toward the DSP
- BusReady  input  1  DSP accepts the beat
- BusLast  output  1  current beat is the final beat of the burst
- Busy  output  1  asserted in any state other than IDLE

## Operation
- FSM states: IDLE, GRANT, XFER, RELEASE.
- IDLE -> GRANT when any Req bit is 1 at the clock edge.
  - Winner is the first set Req bit searched upward from Ptr, wrapping modulo NREQ.
  - On the same edge: latch winner index, load AddrBus from ReqAddr[winner], load BeatCnt from ReqLen[winner].
- GRANT -> XFER unconditionally, after one cycle.
  - Gnt[winner] is asserted from GRANT onward.
- XFER:
  - BusValid = 1.
  - DataBus = ReqData[winner], combinational mux.
  - BusLast = (BeatCnt == 0).
  - On BusValid & BusReady: BeatAck[winner] = 1 (combinational), AddrBus += 1 (wraps modulo 2^AW), BeatCnt -= 1.
  - If BusLast at that beat, go to RELEASE.
  - BusReady low: hold all bus outputs stable, with no limit on wait cycles.
- RELEASE -> IDLE after one cycle.
  - Gnt = 0 and BusValid = 0 (bus turnaround).
  - Ptr = winner + 1, modulo NREQ.
- Req deasserting after grant is ignored; the committed burst runs to completion.
- Req changes of non-winners during a transaction have no effect until the next IDLE.
- A requester presents its next beat's ReqData in the cycle after its BeatAck.
- DataBus, BusLast and BeatAck are 0 outside XFER.

## Timing
- Reset values: Gnt=0, BeatAck=0, BusValid=0, BusLast=0, AddrBus=0, DataBus=0, Busy=0. State=IDLE, Ptr=0.
- Reset asserted mid-burst aborts the transfer at that edge; no further BeatAck is issued.
- Latency with BusReady tied high, Req sampled at edge 0:
  - GRANT in cycle 1.
  - First beat valid in cycle 2.
  - An N-beat burst completes in cycle 1+N.
  - RELEASE in cycle 2+N, IDLE in cycle 3+N.
  - Minimum period between back-to-back grants: N+3 cycles.
- Simultaneous requests: resolved purely by Ptr. After winner k, requester k has lowest priority.
- A single persistent requester is re-granted every N+3 cycles.
- Address wrap: AddrBus=8'hFF with 2 beats left gives 8'h00 on the next beat.

## Test plan
- Reset, then Req=4'b0001, ReqAddr0=8'h10, ReqLen0=2, BusReady=1:
  - Gnt=0001 from cycle 1.
  - Beats at AddrBus 10, 11, 12 in cycles 2-4; BusLast only in cycle 4.
  - Busy drops in cycle 6.
- Req=4'b1111 held, all ReqLen=0: grants in order 0, 1, 2, 3, 0, one every 4 cycles.
- Single beat, BusReady low for 3 cycles:
  - BusValid, AddrBus and DataBus hold stable.
  - BeatAck pulses exactly once, in the cycle BusReady goes high.
- ReqAddr=8'hFE, ReqLen=3 gives AddrBus sequence FE, FF, 00, 01.
- Winner drops Req in its first XFER cycle: all 4 beats still complete.
- Reset asserted on the 2nd beat of a 4-beat burst:
  - Next cycle: all outputs 0, state IDLE.
  - Re-request from requester 2 is granted first (Ptr=0, search from 0, only requester 2 requesting).
